// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between instruction fetch and data access
// Data requests normally win; a streak counter bounds how long a pending fetch can wait.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] streak;
  logic       op_wr;
  logic       d_pend;
  logic       d_grant;

  assign d_pend  = dREN | dWEN;
  // A pending fetch that has already lost SMAX times in a row takes priority.
  assign d_grant = d_pend && !(iREN && (streak == SMAX));

  // ramaddr/ramstore double as the latched request so they naturally hold between accesses.
  always_ff @(posedge clk, negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      streak   <= 4'd0;
      op_wr    <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            op_wr    <= dWEN;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            if (!iREN)
              streak <= 4'd0;
            else if (streak != SMAX)
              streak <= streak + 4'd1;
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            streak  <= 4'd0;
          end
        end
        IACC: begin
          if (ram_ready) begin
            ramREN <= 1'b0;
            iload  <= ramload;
            ihit   <= 1'b1;
            state  <= IDONE;
          end
        end
        DACC: begin
          if (ram_ready) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (!op_wr)
              dload <= ramload;
            dhit  <= 1'b1;
            state <= DDONE;
          end
        end
        IDONE: begin
          ihit  <= 1'b0;
          state <= IDLE;
        end
        DDONE: begin
          dhit  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Table-driven requests against a wait-state RAM model; a queue scoreboard checks accesses and hits.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, ram_ready;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, dw, mid;
    logic [31:0] ia, da, ds;
    int          wt, lat_d, lat_i;
  } vec_t;

  typedef struct {
    logic        is_d, is_wr;
    logic [31:0] addr, store, load;
    int          lat, t0;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ram_wait = 1;
  int   rcnt = 0;
  logic rdy_force = 1'b0;
  logic mon_en = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] exp_dload = 32'h0;
  exp_t exq[$];
  exp_t e;
  vec_t vecs [8];

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, none required (cycle %0d)", nm, cyc);
  endtask

  // RAM model: ready after ram_wait access cycles; writes land on the ready edge.
  assign ram_ready = rdy_force | ((ramREN | ramWEN) && (rcnt == ram_wait - 1));
  assign ramload   = mem[idx(ramaddr)];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!(ramREN | ramWEN) || ram_ready) rcnt <= 0;
    else rcnt <= rcnt + 1;
    if (ramWEN && ram_ready) mem[idx(ramaddr)] <= ramstore;
  end

  task automatic push_i(input logic [31:0] a, input int lat, input int t0);
    exp_t x;
    x = '{1'b0, 1'b0, a, 32'h0, shadow[idx(a)], lat, t0};
    exq.push_back(x);
  endtask

  task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] s,
                        input int lat, input int t0);
    exp_t x;
    if (wr) shadow[idx(a)] = s;
    else exp_dload = shadow[idx(a)];
    x = '{1'b1, wr, a, s, exp_dload, lat, t0};
    exq.push_back(x);
  endtask

  // Scoreboard monitor: every access cycle is checked against the head, every hit pops it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ramREN || ramWEN) begin
        if (exq.size() == 0) flag("unexpected_access");
        else begin
          check("acc_wen", 64'(ramWEN), 64'(exq[0].is_d & exq[0].is_wr));
          check("acc_ren", 64'(ramREN), 64'(!(exq[0].is_d & exq[0].is_wr)));
          check("acc_addr", 64'(ramaddr), 64'(exq[0].addr));
          if (ramWEN) check("acc_store", 64'(ramstore), 64'(exq[0].store));
        end
      end
      if (ihit || dhit) begin
        if (exq.size() == 0) flag("unexpected_hit");
        else begin
          e = exq.pop_front();
          check("hit_both", 64'(ihit & dhit), 64'(0));
          check("hit_is_d", 64'(dhit), 64'(e.is_d));
          if (e.is_d) check("dload", 64'(dload), 64'(e.load));
          else check("iload", 64'(iload), 64'(e.load));
          if (e.lat > 0) check("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  t0;
    logic il, dl;
    @(posedge clk); #1;
    ram_wait = v.wt;
    iREN = v.ir; iaddr = v.ia;
    dREN = v.dr; dWEN = v.dw; daddr = v.da; dstore = v.ds;
    t0 = cyc;
    if (v.dr | v.dw) push_d(v.dw, v.da, v.ds, v.lat_d, t0);
    if (v.ir) push_i(v.ia, v.lat_i, t0);
    il = v.ir;
    dl = v.dr | v.dw;
    for (int c = 0; c < 200 && (il || dl); c++) begin
      @(negedge clk);
      if (v.mid && cyc == t0 + 1) begin
        daddr  = v.da ^ 32'h0000_0FF0;
        dstore = ~v.ds;
      end
      if (dhit) begin dREN = 1'b0; dWEN = 1'b0; dl = 1'b0; end
      if (ihit) begin iREN = 1'b0; il = 1'b0; end
    end
    if (il || dl) flag("vector_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ramREN"}, 64'(ramREN), 64'(0));
    check({tag, "_ramWEN"}, 64'(ramWEN), 64'(0));
    check({tag, "_ihit"}, 64'(ihit), 64'(0));
    check({tag, "_dhit"}, 64'(dhit), 64'(0));
    check({tag, "_ramaddr"}, 64'(ramaddr), 64'(0));
    check({tag, "_ramstore"}, 64'(ramstore), 64'(0));
    check({tag, "_iload"}, 64'(iload), 64'(0));
    check({tag, "_dload"}, 64'(dload), 64'(0));
  endtask

  initial begin
    int dcnt, icnt;
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    for (int k = 0; k < 256; k++) begin
      mem[k]    = 32'h1000_0000 + 32'(k);
      shadow[k] = 32'h1000_0000 + 32'(k);
    end
    mem[16]    = 32'h2402_0005;
    shadow[16] = 32'h2402_0005;

    //         ir    dr    dw    mid   ia            da            ds            wt d  i
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        2, 0, 3};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0F00, 32'hDEAD_BEEF, 1, 2, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0F00, 32'h0,        1, 2, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0080, 32'h0,        1, 2, 5};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h0000_0100, 32'h1234_5678, 3, 4, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0100, 32'h0,        1, 2, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0200, 32'hCAFE_F00D, 2, 3, 7};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        1, 0, 2};

    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst0");
    @(negedge clk);
    nRST = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Starvation: fetch held, data re-requested every IDLE cycle -> D, D, I, D, D, I.
    @(posedge clk); #1;
    ram_wait = 1;
    push_d(1'b0, 32'h400, 32'h0, 0, cyc);
    push_d(1'b0, 32'h404, 32'h0, 0, cyc);
    push_i(32'h300, 0, cyc);
    push_d(1'b0, 32'h408, 32'h0, 0, cyc);
    push_d(1'b0, 32'h40C, 32'h0, 0, cyc);
    push_i(32'h304, 0, cyc);
    iREN = 1'b1; iaddr = 32'h300;
    dREN = 1'b1; daddr = 32'h400;
    dcnt = 0; icnt = 0;
    for (int c = 0; c < 300 && (dcnt < 4 || icnt < 2); c++) begin
      @(negedge clk);
      if (dhit) begin
        dcnt++;
        if (dcnt < 4) daddr = 32'h400 + 32'(4 * dcnt);
        else dREN = 1'b0;
      end
      if (ihit) begin
        icnt++;
        if (icnt < 2) iaddr = 32'h304;
        else iREN = 1'b0;
      end
    end
    check("starve_d_hits", 64'(dcnt), 64'(4));
    check("starve_i_hits", 64'(icnt), 64'(2));
    iREN = 1'b0; dREN = 1'b0;

    // ram_ready while idle must not start or finish anything.
    @(negedge clk);
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);
    rdy_force = 1'b0;
    check("idle_ready_ignored", 64'(ramREN | ramWEN | ihit | dhit), 64'(0));

    // Asynchronous reset in the middle of a data access.
    @(posedge clk); #1;
    ram_wait = 5;
    dREN = 1'b1; daddr = 32'h80;
    push_d(1'b0, 32'h80, 32'h0, 0, cyc);
    repeat (2) @(negedge clk);
    check("pre_reset_in_dacc", 64'(ramREN), 64'(1));
    mon_en = 1'b0;
    nRST = 1'b0;
    #1 check_reset_outputs("rst_mid");
    dREN = 1'b0;
    exq.delete();
    exp_dload = 32'h0;
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_reset_idle", 64'(ramREN | ramWEN | ihit | dhit), 64'(0));
    end

    run_vec(vecs[0]);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares the single-ported RAM between the CPU instruction-fetch path and the data-access path. It latches one request at a time, drives the RAM port until the RAM reports completion, and returns read data with a one-cycle hit pulse. The hit pulses feed the request unit, which uses them to advance the PC and drop the data memory enables. Data requests normally win; a streak counter guarantees that instruction fetches cannot be starved.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data word width in bits
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending (legal range 1..15)

- clk  in  1  clock, all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request; held by the requester until ihit
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data; valid while ihit=1
- ihit  out  1  one-cycle completion pulse for the instruction request
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit; wins over dREN if both are high
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dload  out  DATA_W  data read data; valid while dhit=1
- dhit  out  1  one-cycle completion pulse for the data request
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data; valid when ram_ready=1
- ram_ready  in  1  RAM completion strobe for the current access

## Operation
- The FSM has five states: IDLE, IACC, DACC, IDONE, DDONE.
- **IDLE, grant selection:**
  - A data request is pending when dREN or dWEN is high.
  - If a data request is pending, and not (iREN=1 and streak==STARVE_MAX), go to DACC.
  - Otherwise, if iREN=1, go to IACC.
  - Otherwise, stay in IDLE.
- **At grant, latch the request into internal registers:**
  - I grant: latch iaddr.
  - D grant: latch daddr and dstore, and op=write if dWEN else read.
  - Request inputs are not sampled again until the next IDLE cycle.
- **Streak counter (4 bits):**
  - On a D grant with iREN=1: streak+1, saturating at STARVE_MAX.
  - On a D grant with iREN=0: streak cleared to 0.
  - On an I grant: streak cleared to 0.
- **IACC:**
  - ramREN=1, ramWEN=0, ramaddr = latched address.
  - When ram_ready=1, capture ramload into iload and go to IDONE.
- **DACC:**
  - Latched write: ramWEN=1, ramREN=0, ramstore = latched data.
  - Latched read: ramREN=1, ramWEN=0.
  - ramaddr = latched address.
  - When ram_ready=1, go to DDONE; on a read, also capture ramload into dload.
- **IDONE:** ihit=1 for exactly this cycle, then go to IDLE.
- **DDONE:** dhit=1 for exactly this cycle, then go to IDLE. dload is left unchanged after a write.
- **RAM port outside IACC and DACC:** ramREN=ramWEN=0. ramaddr and ramstore hold their last values.
- **Request changes while an access is in flight:** ignored. The latched transaction completes as latched.
- **Requester withdraws before its hit:** the transaction still completes and its hit still pulses.

## Timing
- **Reset (nRST=0, asynchronous):**
  - state=IDLE, streak=0.
  - ramREN, ramWEN, ihit, dhit = 0.
  - ramaddr, ramstore, iload, dload = 0.
  - An in-flight access is abandoned with no hit.
- **Latency:** request seen in IDLE at edge E → ram enable asserted in cycle E+1 → ram_ready at edge E+k (k≥1) → hit high during cycle E+k+1.
  - Minimum is 3 cycles from request to hit, with ram_ready=1 on the first access cycle.
- **Back-to-back:** the cycle after a hit is IDLE, so the next grant edge ends that cycle. Sustained rate with a zero-wait RAM is one transaction per 3 cycles.
- **Handshake:** a requester must deassert or change its request in the cycle following its hit. IDLE samples requests at the edge that ends the IDLE cycle, so the completed request is never re-granted.
- **Simultaneous iREN and data request in IDLE:** data is granted unless streak==STARVE_MAX.
- **ram_ready in IDLE, IDONE or DDONE:** ignored.
- **Outputs are registered:** no combinational path from any input to any output.

## Test plan
- **Reset:** assert nRST=0 mid-DACC → all outputs 0 immediately; after release with no requests, state stays IDLE and no hit ever pulses.
- **Instruction read:** iREN=1, iaddr=0x0000_0040, ram_ready after 2 access cycles, ramload=0x2402_0005 → ramREN=1 with ramaddr=0x40 for 2 cycles; then ihit=1 for one cycle with iload=0x2402_0005.
- **Data write:** dWEN=1, daddr=0x0000_0F00, dstore=0xDEAD_BEEF, ram_ready on the 1st access cycle → ramWEN=1, ramstore=0xDEADBEEF; dhit pulses 3 cycles after the request; dload unchanged.
- **Contention:** iREN and dREN both high at the same edge → DACC first and dhit; the IACC grant begins the cycle after the IDLE cycle that follows the dhit (next grant edge).
- **Starvation:** STARVE_MAX=2, iREN held high, new data request re-asserted in every IDLE cycle → grant order D, D, I, D, D, I.
- **Dual enable and mid-flight change:** dREN=dWEN=1 → write performed. Changing daddr during DACC does not change ramaddr.
